// File: rtl/twos_comp_pkg.sv
// ----------------------------------------------------------------------------
// twos_comp_pkg
// Shared types and helpers for the bit-serial two's-complement unit.
//   mode_e    : operation selected with each operand word
//   state_e   : control FSM states of twos_comp_serial
//   init_ctrl : decodes mode and operand MSB into {inv, carry0}
// ----------------------------------------------------------------------------
package twos_comp_pkg;

   typedef enum logic [1:0] {
      PASS = 2'b00,
      ONES = 2'b01,
      TWOS = 2'b10,
      ABS  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Absolute value is a conditional negation: only negative operands
   // (MSB set) get inverted and incremented.
   function automatic logic [1:0] init_ctrl(input logic [1:0] mode, input logic msb);
      logic inv;
      logic carry0;
      inv    = 1'b0;
      carry0 = 1'b0;
      case (mode_e'(mode))
         ONES: begin
            inv = 1'b1;
         end
         TWOS: begin
            inv    = 1'b1;
            carry0 = 1'b1;
         end
         ABS: begin
            inv    = msb;
            carry0 = msb;
         end
         default: begin
            inv    = 1'b0;
            carry0 = 1'b0;
         end
      endcase
      return {inv, carry0};
   endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// ----------------------------------------------------------------------------
// comp_bit_cell
// One-bit complement/increment cell with its carry flip-flop.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : seed the carry with carry0 on this edge (word accept)
//   carry0   : initial carry for the incoming word
//   a_bit    : current operand bit, LSB first
//   inv      : invert the operand bit before the increment
//   z_bit    : result bit for the current position (combinational)
// ----------------------------------------------------------------------------
module comp_bit_cell
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic carry0,
   input  logic a_bit,
   input  logic inv,
   output logic z_bit
);

   logic r_carry;
   logic w_bitInv;

   assign w_bitInv = a_bit ^ inv;
   assign z_bit    = w_bitInv ^ r_carry;

   // Half-adder carry chain, one position per clock. Outside a word the
   // carry free-runs harmlessly; the accept edge always reseeds it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_carry <= 1'b0;
      end else if (load) begin
         r_carry <= carry0;
      end else begin
         r_carry <= w_bitInv & r_carry;
      end
   end

endmodule

// File: rtl/twos_comp_serial.sv
// ----------------------------------------------------------------------------
// twos_comp_serial
// Bit-serial pass / ones' / two's complement / absolute-value unit. Accepts
// one WIDTH-bit word, walks it LSB-first through a single comp_bit_cell and
// presents the result word plus a negation-overflow flag.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   mode, a              : operation and operand, sampled on accept
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   z, ovf               : result and overflow, held until the next word ends
// ----------------------------------------------------------------------------
module twos_comp_serial
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             ovf
);

   import twos_comp_pkg::*;

   localparam int CNT_W = $clog2(WIDTH);

   state_e             r_state;
   state_e             w_nextState;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_opA;
   logic [WIDTH-1:0]   r_shift;
   logic [WIDTH-1:0]   r_z;
   logic               r_inv;
   logic               r_carry0;
   logic               r_msb;
   logic               r_ovf;
   logic               w_accept;
   logic               w_lastBit;
   logic               w_zBit;
   logic [1:0]         w_ctrl;

   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_lastBit = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
   assign w_ctrl    = init_ctrl(mode, a[WIDTH-1]);

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign z         = r_z;
   assign ovf       = r_ovf;

   comp_bit_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .load   (w_accept),
      .carry0 (w_ctrl[0]),
      .a_bit  (r_opA[0]),
      .inv    (r_inv),
      .z_bit  (w_zBit)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: accept in IDLE, leave RUN after the MSB, and wait
   // in DONE for as long as the consumer applies backpressure.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (w_lastBit) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath. Result bits collect in r_shift while running and are copied
   // to r_z only on the final edge, so z never shows a partial word and a
   // reset mid-word leaves nothing behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_opA    <= '0;
         r_shift  <= '0;
         r_z      <= '0;
         r_inv    <= 1'b0;
         r_carry0 <= 1'b0;
         r_msb    <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_opA    <= a;
         r_inv    <= w_ctrl[1];
         r_carry0 <= w_ctrl[0];
         r_msb    <= a[WIDTH-1];
      end else if (r_state == RUN) begin
         r_cnt   <= r_cnt + CNT_W'(1);
         r_opA   <= {1'b0, r_opA[WIDTH-1:1]};
         r_shift <= {w_zBit, r_shift[WIDTH-1:1]};
         if (w_lastBit) begin
            r_z   <= {w_zBit, r_shift[WIDTH-1:1]};
            r_ovf <= r_carry0 & r_msb & w_zBit;
         end
      end
   end

endmodule

// File: tb/tb_twos_comp_serial.sv
// ----------------------------------------------------------------------------
// tb_twos_comp_serial
// Directed bench for twos_comp_serial at WIDTH=8 and WIDTH=16.
// ----------------------------------------------------------------------------
module tb_twos_comp_serial;

   logic        clk;
   logic        rst;

   logic        inValid8;
   logic        inReady8;
   logic [1:0]  mode8;
   logic [7:0]  a8;
   logic        outValid8;
   logic        outReady8;
   logic [7:0]  z8;
   logic        ovf8;

   logic        inValid16;
   logic        inReady16;
   logic [1:0]  mode16;
   logic [15:0] a16;
   logic        outValid16;
   logic        outReady16;
   logic [15:0] z16;
   logic        ovf16;

   int checks;
   int errors;
   int lat;

   typedef struct {
      logic [1:0] m;
      logic [7:0] a;
      logic [7:0] z;
      logic       ovf;
   } vec_t;

   vec_t vecs[13];

   twos_comp_serial #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid8),
      .in_ready  (inReady8),
      .mode      (mode8),
      .a         (a8),
      .out_valid (outValid8),
      .out_ready (outReady8),
      .z         (z8),
      .ovf       (ovf8)
   );

   twos_comp_serial #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid16),
      .in_ready  (inReady16),
      .mode      (mode16),
      .a         (a16),
      .out_valid (outValid16),
      .out_ready (outReady16),
      .z         (z16),
      .ovf       (ovf16)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Presents one word to the 8-bit unit for exactly one accept edge.
   // Called #1 after an edge with the unit in IDLE.
   task automatic applyStimulus(input logic [1:0] m, input logic [7:0] av);
      mode8    = m;
      a8       = av;
      inValid8 = 1'b1;
      @(posedge clk);
      #1;
      inValid8 = 1'b0;
      mode8    = ~m;
      a8       = ~av;
   endtask

   // Counts edges after the accept edge until out_valid rises (bounded).
   task automatic waitResult8(output int n);
      n = 0;
      while (!outValid8 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int accepts[$];
      int cyc;

      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      inValid8   = 1'b0;
      mode8      = 2'b00;
      a8         = 8'h00;
      outReady8  = 1'b1;
      inValid16  = 1'b0;
      mode16     = 2'b00;
      a16        = 16'h0000;
      outReady16 = 1'b1;

      vecs[0]  = '{2'b10, 8'hBB, 8'h45, 1'b0};
      vecs[1]  = '{2'b01, 8'hBB, 8'h44, 1'b0};
      vecs[2]  = '{2'b11, 8'hBB, 8'h45, 1'b0};
      vecs[3]  = '{2'b11, 8'h45, 8'h45, 1'b0};
      vecs[4]  = '{2'b10, 8'h80, 8'h80, 1'b1};
      vecs[5]  = '{2'b11, 8'h80, 8'h80, 1'b1};
      vecs[6]  = '{2'b10, 8'h00, 8'h00, 1'b0};
      vecs[7]  = '{2'b00, 8'h5A, 8'h5A, 1'b0};
      vecs[8]  = '{2'b01, 8'h00, 8'hFF, 1'b0};
      vecs[9]  = '{2'b11, 8'h00, 8'h00, 1'b0};
      vecs[10] = '{2'b10, 8'h01, 8'hFF, 1'b0};
      vecs[11] = '{2'b11, 8'hFF, 8'h01, 1'b0};
      vecs[12] = '{2'b10, 8'h7F, 8'h81, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset in_ready",  {31'b0, inReady8},  32'h1);
      checkOutput("reset out_valid", {31'b0, outValid8}, 32'h0);
      checkOutput("reset z",         {24'b0, z8},        32'h0);
      checkOutput("reset ovf",       {31'b0, ovf8},      32'h0);

      // Table-driven words with the consumer always ready.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].m, vecs[i].a);
         waitResult8(lat);
         checkOutput($sformatf("vec%0d latency", i), lat, 32'd8);
         checkOutput($sformatf("vec%0d z", i), {24'b0, z8}, {24'b0, vecs[i].z});
         checkOutput($sformatf("vec%0d ovf", i), {31'b0, ovf8}, {31'b0, vecs[i].ovf});
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d idle", i), {30'b0, inReady8, outValid8}, 32'h2);
         checkOutput($sformatf("vec%0d z held", i), {24'b0, z8}, {24'b0, vecs[i].z});
      end

      // Backpressure: DONE holds while inputs churn.
      outReady8 = 1'b0;
      applyStimulus(2'b11, 8'h80);
      waitResult8(lat);
      checkOutput("bp latency", lat, 32'd8);
      for (int i = 0; i < 5; i++) begin
         mode8    = 2'(i);
         a8       = 8'(8'h11 * i);
         inValid8 = ~inValid8;
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp%0d z", i), {24'b0, z8}, 32'h80);
         checkOutput($sformatf("bp%0d ovf", i), {31'b0, ovf8}, 32'h1);
         checkOutput($sformatf("bp%0d hs", i), {30'b0, inReady8, outValid8}, 32'h1);
      end
      inValid8  = 1'b0;
      outReady8 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp release", {30'b0, inReady8, outValid8}, 32'h2);
      checkOutput("bp z kept", {24'b0, z8}, 32'h80);

      // Reset while cnt==3 abandons the word.
      applyStimulus(2'b10, 8'h3C);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst hs", {30'b0, inReady8, outValid8}, 32'h2);
      checkOutput("midrst z", {24'b0, z8}, 32'h0);
      checkOutput("midrst ovf", {31'b0, ovf8}, 32'h0);
      applyStimulus(2'b10, 8'h3C);
      waitResult8(lat);
      checkOutput("postrst latency", lat, 32'd8);
      checkOutput("postrst z", {24'b0, z8}, 32'hC4);
      @(posedge clk);
      #1;

      // WIDTH=16 single word.
      mode16    = 2'b10;
      a16       = 16'h0001;
      inValid16 = 1'b1;
      @(posedge clk);
      #1;
      inValid16 = 1'b0;
      lat = 0;
      while (!outValid16 && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("w16 latency", lat, 32'd16);
      checkOutput("w16 z", {16'b0, z16}, 32'hFFFF);
      checkOutput("w16 ovf", {31'b0, ovf16}, 32'h0);
      @(posedge clk);
      #1;

      // WIDTH=16 back-to-back: in_valid and out_ready held high.
      inValid16 = 1'b1;
      cyc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (inReady16) begin
            accepts.push_back(cyc);
         end
         @(posedge clk);
         cyc++;
      end
      #1;
      inValid16 = 1'b0;
      checkOutput("b2b accepts", (accepts.size() >= 3) ? 32'h1 : 32'h0, 32'h1);
      if (accepts.size() >= 3) begin
         checkOutput("b2b period0", accepts[1] - accepts[0], 32'd18);
         checkOutput("b2b period1", accepts[2] - accepts[1], 32'd18);
      end
      checkOutput("b2b z", {16'b0, z16}, 32'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
